// File: rtl/lock_code_pkg.sv
//------------------------------------------------------------------------------
// Module : lock_code_pkg
// Brief  : Shared state encoding and default code for the lock-code sender.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package lock_code_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int         DEF_CODE_W = 4;
    localparam logic [3:0] DEF_CODE   = 4'b1011;

endpackage

`default_nettype wire

// File: rtl/lock_code_shreg.sv
//------------------------------------------------------------------------------
// Module : lock_code_shreg
// Brief  : Loadable MSB-first shift register; zeros shift in behind the code.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module lock_code_shreg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clear,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic [WIDTH-1:0] i_value,
    output logic             o_msb
);

    logic [WIDTH-1:0] r_data;

    // clear has priority so an abort wins over a same-cycle reload
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data <= '0;
        end else if (i_clear) begin
            r_data <= '0;
        end else if (i_load) begin
            r_data <= i_value;
        end else if (i_shift) begin
            r_data <= {r_data[WIDTH-2:0], 1'b0};
        end
    end

    assign o_msb = r_data[WIDTH-1];

endmodule

`default_nettype wire

// File: rtl/lock_code_sender.sv
//------------------------------------------------------------------------------
// Module : lock_code_sender
// Brief  : Serial lock-code transmitter with repeat count, gaps and handshake.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module lock_code_sender
    import lock_code_pkg::*;
#(
    parameter int                CODE_W     = DEF_CODE_W,
    parameter logic [CODE_W-1:0] CODE       = CODE_W'(DEF_CODE),
    parameter int                GAP_CYCLES = 2,
    parameter int                REP_W      = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_code,
    input  logic [CODE_W-1:0] code_in,
    input  logic              start,
    input  logic [REP_W-1:0]  repeat_n,
    input  logic              abort,
    output logic              dout,
    output logic              dout_valid,
    output logic              busy,
    output logic              done
);

    localparam int                 c_IDX_W    = $clog2(CODE_W);
    localparam int                 c_GAP_W    = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [c_IDX_W-1:0] c_IDX_MSB  = c_IDX_W'(CODE_W - 1);
    localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [REP_W-1:0]   c_REP_ONE  = REP_W'(1);

    state_t              r_state, w_state_nxt;
    logic [c_IDX_W-1:0]  r_bit_idx, w_bit_idx_nxt;
    logic [REP_W-1:0]    r_reps, w_reps_nxt;
    logic [c_GAP_W-1:0]  r_gap_cnt, w_gap_cnt_nxt;
    logic [CODE_W-1:0]   r_code, w_code_nxt;
    logic                r_valid, w_valid_nxt;
    logic                r_busy, w_busy_nxt;
    logic                r_done, w_done_nxt;
    logic                w_sh_clear, w_sh_load, w_sh_shift;

    always_comb begin
        w_state_nxt   = r_state;
        w_bit_idx_nxt = r_bit_idx;
        w_reps_nxt    = r_reps;
        w_gap_cnt_nxt = r_gap_cnt;
        w_code_nxt    = r_code;
        w_valid_nxt   = 1'b0;
        w_busy_nxt    = 1'b0;
        w_done_nxt    = 1'b0;
        w_sh_clear    = 1'b0;
        w_sh_load     = 1'b0;
        w_sh_shift    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (load_code) begin
                    w_code_nxt = code_in;
                end
                // the shift register loads w_code_nxt so a same-cycle load wins
                if (start) begin
                    w_state_nxt   = ST_SEND;
                    w_reps_nxt    = (repeat_n == '0) ? c_REP_ONE : repeat_n;
                    w_bit_idx_nxt = c_IDX_MSB;
                    w_sh_load     = 1'b1;
                    w_valid_nxt   = 1'b1;
                    w_busy_nxt    = 1'b1;
                end
            end
            ST_SEND: begin
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                    w_sh_clear  = 1'b1;
                end else if (r_bit_idx != '0) begin
                    w_bit_idx_nxt = r_bit_idx - c_IDX_W'(1);
                    w_sh_shift    = 1'b1;
                    w_valid_nxt   = 1'b1;
                    w_busy_nxt    = 1'b1;
                end else if (r_reps != c_REP_ONE) begin
                    w_reps_nxt = r_reps - c_REP_ONE;
                    w_busy_nxt = 1'b1;
                    if (GAP_CYCLES == 0) begin
                        w_bit_idx_nxt = c_IDX_MSB;
                        w_sh_load     = 1'b1;
                        w_valid_nxt   = 1'b1;
                    end else begin
                        w_state_nxt   = ST_GAP;
                        w_gap_cnt_nxt = '0;
                        w_sh_clear    = 1'b1;
                    end
                end else begin
                    w_state_nxt = ST_DONE;
                    w_sh_clear  = 1'b1;
                    w_done_nxt  = 1'b1;
                end
            end
            ST_GAP: begin
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                    w_sh_clear  = 1'b1;
                end else if (r_gap_cnt == c_GAP_LAST) begin
                    w_state_nxt   = ST_SEND;
                    w_bit_idx_nxt = c_IDX_MSB;
                    w_sh_load     = 1'b1;
                    w_valid_nxt   = 1'b1;
                    w_busy_nxt    = 1'b1;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt + c_GAP_W'(1);
                    w_busy_nxt    = 1'b1;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_bit_idx <= '0;
            r_reps    <= '0;
            r_gap_cnt <= '0;
            r_code    <= CODE;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_reps    <= w_reps_nxt;
            r_gap_cnt <= w_gap_cnt_nxt;
            r_code    <= w_code_nxt;
            r_valid   <= w_valid_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
        end
    end

    lock_code_shreg #(
        .WIDTH (CODE_W)
    ) u_shreg (
        .clk     (clk),
        .reset   (reset),
        .i_clear (w_sh_clear),
        .i_load  (w_sh_load),
        .i_shift (w_sh_shift),
        .i_value (w_code_nxt),
        .o_msb   (dout)
    );

    assign dout_valid = r_valid;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule

`default_nettype wire
